// File: rtl/przesuniecie_arbiter.sv
// ============================================================================
//  Module      : przesuniecie_arbiter
//  Description : Round-robin arbiter that lets two requesters share a single
//                combinational arithmetic-shift unit (przesuniecie). The
//                winner's operands are registered onto the shifter, and the
//                result/error are returned on a response channel tagged with
//                the requester ID.
//  Options     : PRZESUNIECIE_ARB_ERRCNT_EN adds o_err_cnt, a saturating
//                8-bit count of responses returned with o_rsp_error=1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module przesuniecie_arbiter #(
    parameter int BITS = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0_valid,
    input  logic [BITS-1:0]   i_req0_arg_A,
    input  logic [BITS-1:0]   i_req0_arg_B,
    output logic              o_req0_ready,
    input  logic              i_req1_valid,
    input  logic [BITS-1:0]   i_req1_arg_A,
    input  logic [BITS-1:0]   i_req1_arg_B,
    output logic              o_req1_ready,
    output logic [BITS-1:0]   o_sh_arg_A,
    output logic [BITS-1:0]   o_sh_arg_B,
    input  logic [BITS-1:0]   i_sh_result,
    input  logic              i_sh_error,
    output logic              o_rsp_valid,
    output logic              o_rsp_id,
    output logic [BITS-1:0]   o_rsp_result,
    output logic              o_rsp_error,
    input  logic              i_rsp_ready
`ifdef PRZESUNIECIE_ARB_ERRCNT_EN
    ,output logic [7:0]       o_err_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_ptr;
    logic              w_any_valid;
    logic              w_gnt_id;
    logic              w_accept;
    logic              w_rsp_done;
    logic [BITS-1:0]   r_arg_a;
    logic [BITS-1:0]   r_arg_b;
    logic              r_id;
    logic [BITS-1:0]   r_rsp_result;
    logic              r_rsp_error;

    // Grant selection: pointer side wins if it is valid, otherwise the other side.
    always_comb begin
        w_any_valid = i_req0_valid | i_req1_valid;
        w_gnt_id    = r_ptr ? i_req1_valid : ~i_req0_valid;
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and handshake outputs; readies only ever assert in IDLE.
    always_comb begin
        w_state_nxt  = r_state;
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        o_rsp_valid  = 1'b0;
        w_accept     = 1'b0;
        w_rsp_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_valid) begin
                    o_req0_ready = ~w_gnt_id;
                    o_req1_ready = w_gnt_id;
                    w_accept     = 1'b1;
                    w_state_nxt  = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand latch on acceptance and result capture at the end of EXEC.
    // Operands stay put afterwards so the shifter inputs do not toggle in IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr        <= 1'b0;
            r_arg_a      <= '0;
            r_arg_b      <= '0;
            r_id         <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_error  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_arg_a <= w_gnt_id ? i_req1_arg_A : i_req0_arg_A;
                r_arg_b <= w_gnt_id ? i_req1_arg_B : i_req0_arg_B;
                r_id    <= w_gnt_id;
                r_ptr   <= ~w_gnt_id;
            end
            if (r_state == S_EXEC) begin
                r_rsp_error  <= i_sh_error;
                r_rsp_result <= i_sh_error ? '0 : i_sh_result;
            end
        end
    end

`ifdef PRZESUNIECIE_ARB_ERRCNT_EN
    logic [7:0] r_err_cnt;

    // Saturating count of error responses, bumped when the consumer takes one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_cnt <= 8'd0;
        end else if (w_rsp_done && r_rsp_error && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign o_err_cnt = r_err_cnt;
`endif

    assign o_sh_arg_A   = r_arg_a;
    assign o_sh_arg_B   = r_arg_b;
    assign o_rsp_id     = r_id;
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_error  = r_rsp_error;

endmodule

`default_nettype wire
